// File: rtl/pixel_array_controller_if.sv
// Readout-side row handshake between the frame sequencer and the readout buffer.
// Latency: none, this interface only groups wires.
// Backpressure: the consumer holds rd_ready low to keep the current row presented.
interface pixel_array_controller_if #(
  parameter int H  = 2,
  parameter int RW = (H > 1) ? $clog2(H) : 1
);
  logic [H-1:0]  READ_ROW;
  logic [RW-1:0] rd_row;
  logic          rd_valid;
  logic          rd_ready;

  // Sequencer side: presents rows, observes acceptance.
  modport master (
    output READ_ROW,
    output rd_row,
    output rd_valid,
    input  rd_ready
  );

  // Readout buffer side: observes rows, accepts them.
  modport slave (
    input  READ_ROW,
    input  rd_row,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/pixel_array_controller.sv
// Frame sequencer: ERASE -> EXPOSE -> CONVERT (256-step ramp) -> per-row READ, one frame per start.
// Latency: ERASE rises the cycle after start; frame = ERASE_CYCLES + T + 256 + H*(READ_SETTLE+1) with rd_ready high.
// Backpressure: a presented row (rd_valid) is held, select unchanged, until rd_ready; abort wins over everything.
module pixel_array_controller #(
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int ERASE_CYCLES       = 5,
  parameter int READ_SETTLE        = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               expose_time,
  input  logic                     abort,
  output logic                     ERASE,
  output logic                     EXPOSE,
  output logic                     RAMP,
  output logic [7:0]               COUNTER,
  output logic                     busy,
  output logic                     frame_done,
  pixel_array_controller_if.master rd
);

  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  // One shared phase counter covers erase length, exposure length and row settle.
  localparam int MAX_A = (ERASE_CYCLES > READ_SETTLE) ? ERASE_CYCLES : READ_SETTLE;
  localparam int MAX_C = (MAX_A > 255) ? MAX_A : 255;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    exp_q;
  logic          erase_q;
  logic          expose_q;
  logic          ramp_q;
  logic [7:0]    counter_q;
  logic [H-1:0]  read_row_q;
  logic [RW-1:0] rd_row_q;
  logic          rd_valid_q;
  logic          frame_done_q;

  // Frame sequencer: state, phase counters and every output are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      ramp_q       <= 1'b0;
      counter_q    <= '0;
      read_row_q   <= '0;
      rd_row_q     <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // frame_done is a single-cycle pulse unless the last row handshake re-asserts it.
      frame_done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        // Abandon the frame: every control drops at once and no completion is reported.
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        erase_q    <= 1'b0;
        expose_q   <= 1'b0;
        ramp_q     <= 1'b0;
        counter_q  <= '0;
        read_row_q <= '0;
        rd_row_q   <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_ERASE;
              erase_q <= 1'b1;
              cnt_q   <= CW'(1);
              // A zero exposure still gets one EXPOSE cycle so the phase is never skipped.
              exp_q   <= (expose_time == 8'd0) ? 8'd1 : expose_time;
            end
          end

          S_ERASE: begin
            if (cnt_q == CW'(ERASE_CYCLES)) begin
              // Hand straight over to exposure with no dead cycle in between.
              state_q  <= S_EXPOSE;
              erase_q  <= 1'b0;
              expose_q <= 1'b1;
              cnt_q    <= CW'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_EXPOSE: begin
            if (cnt_q == CW'(exp_q)) begin
              state_q   <= S_CONVERT;
              expose_q  <= 1'b0;
              ramp_q    <= 1'b1;
              counter_q <= 8'd0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_CONVERT: begin
            // COUNTER itself times the ramp; it stops at 255 instead of wrapping.
            if (counter_q == 8'd255) begin
              state_q    <= S_READ;
              ramp_q     <= 1'b0;
              counter_q  <= 8'd0;
              read_row_q <= H'(1);
              rd_row_q   <= '0;
              rd_valid_q <= 1'b0;
              cnt_q      <= CW'(1);
            end else begin
              counter_q <= counter_q + 8'd1;
            end
          end

          S_READ: begin
            if (rd_valid_q) begin
              // Row is presented; only an accepting consumer moves us on.
              if (rd.rd_ready) begin
                rd_valid_q <= 1'b0;
                if (rd_row_q == RW'(H - 1)) begin
                  state_q      <= S_IDLE;
                  read_row_q   <= '0;
                  rd_row_q     <= '0;
                  cnt_q        <= '0;
                  frame_done_q <= 1'b1;
                end else begin
                  read_row_q <= read_row_q << 1;
                  rd_row_q   <= rd_row_q + RW'(1);
                  cnt_q      <= CW'(1);
                end
              end
            end else if (cnt_q == CW'(READ_SETTLE)) begin
              // Settle time elapsed: the row's data is stable, present it.
              rd_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ERASE       = erase_q;
  assign EXPOSE      = expose_q;
  assign RAMP        = ramp_q;
  assign COUNTER     = counter_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_IDLE);
  assign rd.READ_ROW = read_row_q;
  assign rd.rd_row   = rd_row_q;
  assign rd.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pixel_array_controller.sv
// Directed bench for pixel_array_controller: H=2 instance fully checked per cycle, H=4 instance for row order.
// Latency: checks sampled on the falling edge, inputs driven there too.
// Backpressure: rd_ready of the H=2 instance is driven by the sequence, H=4 instance always ready.
module tb_pixel_array_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] expose_time;
  logic       abort;

  logic       ERASE, EXPOSE, RAMP, busy, frame_done;
  logic [7:0] COUNTER;
  logic       e4_erase, e4_expose, e4_ramp, e4_busy, e4_done;
  logic [7:0] e4_counter;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  int q4[$];

  pixel_array_controller_if #(.H(2)) rd2 ();
  pixel_array_controller_if #(.H(4)) rd4 ();

  assign rd4.rd_ready = 1'b1;

  pixel_array_controller #(.PIXEL_ARRAY_HEIGHT(2), .ERASE_CYCLES(5), .READ_SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .expose_time(expose_time), .abort(abort),
    .ERASE(ERASE), .EXPOSE(EXPOSE), .RAMP(RAMP), .COUNTER(COUNTER),
    .busy(busy), .frame_done(frame_done), .rd(rd2)
  );

  pixel_array_controller #(.PIXEL_ARRAY_HEIGHT(4), .ERASE_CYCLES(5), .READ_SETTLE(2)) dut4 (
    .clk(clk), .reset(reset), .start(start), .expose_time(expose_time), .abort(abort),
    .ERASE(e4_erase), .EXPOSE(e4_expose), .RAMP(e4_ramp), .COUNTER(e4_counter),
    .busy(e4_busy), .frame_done(e4_done), .rd(rd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // {ERASE,EXPOSE,RAMP,COUNTER[7:0],READ_ROW[1:0],rd_row,rd_valid,busy,frame_done}
  function automatic logic [16:0] obs2();
    return {ERASE, EXPOSE, RAMP, COUNTER, rd2.READ_ROW, rd2.rd_row, rd2.rd_valid, busy, frame_done};
  endfunction

  // Expected output vector j cycles after the start edge, rd_ready high, H=2, erase 5, settle 2.
  function automatic logic [16:0] model(input int j, input int tn);
    logic [16:0] v;
    int cb;
    int r;
    int p;
    v  = '0;
    cb = 5 + tn + 256;
    if (j < 5) begin
      v[16] = 1'b1; v[1] = 1'b1;
    end else if (j < 5 + tn) begin
      v[15] = 1'b1; v[1] = 1'b1;
    end else if (j < cb) begin
      v[14] = 1'b1; v[13:6] = 8'(j - 5 - tn); v[1] = 1'b1;
    end else if (j < cb + 6) begin
      r = (j - cb) / 3;
      p = (j - cb) % 3;
      v[5:4] = (r == 0) ? 2'b01 : 2'b10;
      v[3]   = r[0];
      v[2]   = (p == 2);
      v[1]   = 1'b1;
    end else if (j == cb + 6) begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  // Caller raises start before the call; hold keeps it high through the whole frame.
  task automatic run_frame(input string tag, input int t, input bit hold);
    int tn;
    int last;
    tn   = (t == 0) ? 1 : t;
    last = 5 + tn + 256 + 6;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      chk(tag, j, {15'd0, obs2()}, {15'd0, model(j, tn)});
      if (j == 0 && !hold) start = 1'b0;
    end
  endtask

  // Invariants on both instances every cycle, plus row order capture for the H=4 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0_h2", 0, {31'd0, $onehot0(rd2.READ_ROW)}, 32'd1);
      chk("onehot0_h4", 0, {31'd0, $onehot0(rd4.READ_ROW)}, 32'd1);
      chk("erase_expose_h2", 0, {31'd0, ERASE & EXPOSE}, 32'd0);
      chk("erase_expose_h4", 0, {31'd0, e4_erase & e4_expose}, 32'd0);
      chk("cnt_no_ramp_h2", 0, {31'd0, !RAMP && (COUNTER != 8'd0)}, 32'd0);
      chk("cnt_no_ramp_h4", 0, {31'd0, !e4_ramp && (e4_counter != 8'd0)}, 32'd0);
      if (rd4.rd_valid && rd4.rd_ready) q4.push_back(int'(rd4.rd_row));
    end
  end

  initial begin
    int j;
    reset       = 1'b0;
    start       = 1'b0;
    expose_time = 8'd0;
    abort       = 1'b0;
    rd2.rd_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", 0, {15'd0, obs2()}, 32'd0);
    chk("reset_outs_h4", 0, {19'd0, e4_erase, e4_expose, e4_ramp, e4_counter, rd4.READ_ROW != 4'd0, e4_busy},
        32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 0, {15'd0, obs2()}, 32'd0);

    // Basic frame, T=3, plus H=4 row order
    q4.delete();
    start = 1'b1; expose_time = 8'd3;
    run_frame("f_t3", 3, 1'b0);
    repeat (8) @(negedge clk);
    chk("h4_rows_n", 0, q4.size(), 4);
    for (int i = 0; i < 4; i++) chk("h4_row", i, (i < q4.size()) ? q4[i] : 32'hFFFF, i);

    // Exposure boundaries
    start = 1'b1; expose_time = 8'd0;
    run_frame("f_t0", 0, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; expose_time = 8'd255;
    run_frame("f_t255", 255, 1'b0);
    repeat (8) @(negedge clk);

    // Start held through a frame is ignored; accepted in the frame_done cycle
    start = 1'b1; expose_time = 8'd3;
    run_frame("f_hold", 3, 1'b1);
    run_frame("f_b2b", 3, 1'b0);
    repeat (8) @(negedge clk);

    // Backpressure on row 0
    rd2.rd_ready = 1'b0;
    start = 1'b1; expose_time = 8'd3;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!rd2.rd_valid && j < 400) begin
      @(negedge clk);
      j++;
    end
    chk("bp_valid_at", 0, j, 266);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", i, {28'd0, rd2.rd_valid, rd2.READ_ROW, rd2.rd_row}, {28'd0, 1'b1, 2'b01, 1'b0});
      @(negedge clk);
    end
    rd2.rd_ready = 1'b1;
    chk("bp_still", 0, {28'd0, rd2.rd_valid, rd2.READ_ROW, rd2.rd_row}, {28'd0, 1'b1, 2'b01, 1'b0});
    @(negedge clk);
    chk("bp_row1", 0, {28'd0, rd2.rd_valid, rd2.READ_ROW, rd2.rd_row}, {28'd0, 1'b0, 2'b10, 1'b1});
    repeat (2) @(negedge clk);
    chk("bp_row1_vld", 0, {28'd0, rd2.rd_valid, rd2.READ_ROW, rd2.rd_row}, {28'd0, 1'b1, 2'b10, 1'b1});
    @(negedge clk);
    chk("bp_done", 0, {30'd0, frame_done, busy}, {30'd0, 1'b1, 1'b0});
    repeat (8) @(negedge clk);

    // Abort in CONVERT at COUNTER=100
    start = 1'b1; expose_time = 8'd3;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (COUNTER != 8'd100 && j < 400) begin
      @(negedge clk);
      j++;
    end
    chk("abort_at", 0, j, 108);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outs", 0, {15'd0, obs2()}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_idle", i, {15'd0, obs2()}, 32'd0);
    end
    start = 1'b1; expose_time = 8'd3;
    run_frame("f_after_abort", 3, 1'b0);
    repeat (8) @(negedge clk);

    // Asynchronous reset during EXPOSE
    start = 1'b1; expose_time = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset", 0, {15'd0, obs2()}, {15'd0, model(6, 3)});
    #1 reset = 1'b0;
    #1 chk("async_reset", 0, {15'd0, obs2()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset", 0, {15'd0, obs2()}, 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
